button_conditioner: RTL and testbench

//   Conditions raw Basys-3 push-button inputs into clean, single-cycle request strobes.

---
 rtl/button_conditioner.sv | 151 +++++++++++++++
 tb/tb_button_conditioner.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
//
// Purpose:
//   Turns raw, bouncy, asynchronous push-button levels into clean debounced
//   levels plus single-cycle press/release strobes. One physical press yields
//   exactly one btn_press pulse, which is suitable for driving FIFO write/read
//   request inputs directly.
//
//   Each channel is fully independent and contains:
//     - a SYNC_STAGES-deep metastability synchronizer,
//     - a four-state debounce FSM with its own stability counter,
//     - registered level / press / release outputs.
//
// Parameters:
//   NBTN          number of button channels
//   SYNC_STAGES   synchronizer depth (>= 2)
//   DEBOUNCE_CNT  cycles the synchronized input must hold to change state (>= 2)
//
// Ports:
//   CLK          in   1     system clock
//   RST_N        in   1     asynchronous active-low reset
//   btn_raw      in   NBTN  raw button levels, 1 = pressed
//   btn_level    out  NBTN  debounced level
//   btn_press    out  NBTN  one-cycle strobe on debounced 0->1
//   btn_release  out  NBTN  one-cycle strobe on debounced 1->0
// -----------------------------------------------------------------------------
module button_conditioner #(
    parameter int NBTN         = 3,
    parameter int SYNC_STAGES  = 2,
    parameter int DEBOUNCE_CNT = 1_000_000
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic [NBTN-1:0] btn_raw,
    output logic [NBTN-1:0] btn_level,
    output logic [NBTN-1:0] btn_press,
    output logic [NBTN-1:0] btn_release
);

    localparam int CW = $clog2(DEBOUNCE_CNT);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CNT - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,   // debounced level 0, input quiet
        ARM_P   = 2'd1,   // debounced level 0, qualifying a press
        PRESSED = 2'd2,   // debounced level 1, input held
        ARM_R   = 2'd3    // debounced level 1, qualifying a release
    } state_t;

    genvar gi;
    generate
        for (gi = 0; gi < NBTN; gi++) begin : g_ch
            logic [SYNC_STAGES-1:0] sync_q;
            state_t                 state_q, state_d;
            logic [CW-1:0]          cnt_q, cnt_d;
            logic                   s;
            logic                   level_d;
            logic                   level_q, press_q, release_q;

            // Synchronizer: shift in at bit 0, FSM only looks at the last stage.
            always_ff @(posedge CLK or negedge RST_N) begin
                if (!RST_N) begin
                    sync_q <= '0;
                end else begin
                    sync_q <= {sync_q[SYNC_STAGES-2:0], btn_raw[gi]};
                end
            end

            assign s = sync_q[SYNC_STAGES-1];

            // FSM state and counter registers.
            always_ff @(posedge CLK or negedge RST_N) begin
                if (!RST_N) begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end else begin
                    state_q <= state_d;
                    cnt_q   <= cnt_d;
                end
            end

            // Next-state logic. The counter is cleared on each entry to an ARM
            // state and its terminal value always forces an exit, so it never wraps.
            always_comb begin
                state_d = state_q;
                cnt_d   = cnt_q;
                unique case (state_q)
                    IDLE: begin
                        if (s) begin
                            state_d = ARM_P;
                            cnt_d   = '0;
                        end
                    end
                    ARM_P: begin
                        if (!s) begin
                            state_d = IDLE;
                        end else if (cnt_q == CNT_LAST) begin
                            state_d = PRESSED;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                    PRESSED: begin
                        if (!s) begin
                            state_d = ARM_R;
                            cnt_d   = '0;
                        end
                    end
                    ARM_R: begin
                        if (s) begin
                            state_d = PRESSED;
                        end else if (cnt_q == CNT_LAST) begin
                            state_d = IDLE;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                    default: begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                endcase
            end

            // Debounced level implied by the current state. The output stage
            // registers it and derives the strobes from its edges, so level and
            // strobe always change in the same cycle and a channel can never
            // strobe press and release together. ARM_P <-> IDLE and
            // ARM_R <-> PRESSED bounces leave the level unchanged: no strobe.
            assign level_d = (state_q == PRESSED) || (state_q == ARM_R);

            always_ff @(posedge CLK or negedge RST_N) begin
                if (!RST_N) begin
                    level_q   <= 1'b0;
                    press_q   <= 1'b0;
                    release_q <= 1'b0;
                end else begin
                    level_q   <= level_d;
                    press_q   <= level_d & ~level_q;
                    release_q <= ~level_d & level_q;
                end
            end

            assign btn_level[gi]   = level_q;
            assign btn_press[gi]   = press_q;
            assign btn_release[gi] = release_q;
        end
    endgenerate

endmodule

// File: tb/tb_button_conditioner.sv
// -----------------------------------------------------------------------------
// tb_button_conditioner
//
// Directed-vector bench for button_conditioner with NBTN=3, SYNC_STAGES=2,
// DEBOUNCE_CNT=8. Inputs change on the falling clock edge; outputs are sampled
// on the falling edge. With that timing the first rising edge after an input
// change is "edge 0", and a qualified change must appear on the outputs right
// after edge 11 (2 sync + 1 + 8 debounce).
// -----------------------------------------------------------------------------
module tb_button_conditioner;

    localparam int NBTN = 3;
    localparam int LAT  = 11;

    logic            clk;
    logic            rst_n;
    logic [NBTN-1:0] btn_raw;
    logic [NBTN-1:0] btn_level;
    logic [NBTN-1:0] btn_press;
    logic [NBTN-1:0] btn_release;

    int n_vec;
    int n_bad;

    button_conditioner #(
        .NBTN         (NBTN),
        .SYNC_STAGES  (2),
        .DEBOUNCE_CNT (8)
    ) dut (
        .CLK         (clk),
        .RST_N       (rst_n),
        .btn_raw     (btn_raw),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance one clock; return positioned on the following falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Watch edges 0..edges after an input change. Strobes must be quiet until
    // the final edge, where they must equal exp_press/exp_rel, and the level
    // must then equal exp_level.
    task automatic watch(input string tag, input int edges,
                         input logic [NBTN-1:0] exp_press,
                         input logic [NBTN-1:0] exp_rel,
                         input logic [NBTN-1:0] exp_level);
        for (int i = 0; i <= edges; i++) begin
            tick();
            if (i < edges) begin
                check({tag, "_quiet"}, {29'd0, btn_press | btn_release}, 32'd0);
            end else begin
                check({tag, "_press"}, {29'd0, btn_press}, {29'd0, exp_press});
                check({tag, "_rel"},   {29'd0, btn_release}, {29'd0, exp_rel});
                check({tag, "_level"}, {29'd0, btn_level}, {29'd0, exp_level});
            end
        end
        // Strobe must be exactly one cycle wide.
        tick();
        check({tag, "_1cyc"}, {29'd0, btn_press | btn_release}, 32'd0);
    endtask

    // Hold inputs for n cycles, expecting no strobes and a fixed level.
    task automatic hold(input string tag, input int n, input logic [NBTN-1:0] exp_level);
        for (int i = 0; i < n; i++) begin
            tick();
            check({tag, "_strb"},  {29'd0, btn_press | btn_release}, 32'd0);
            check({tag, "_level"}, {29'd0, btn_level}, {29'd0, exp_level});
        end
    endtask

    initial begin
        n_vec   = 0;
        n_bad   = 0;
        rst_n   = 1'b0;
        btn_raw = 3'b111;

        // 1: reset with all buttons held; outputs stay low.
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("rst_out", {29'd0, btn_level | btn_press | btn_release}, 32'd0);
        end
        rst_n = 1'b1;
        watch("rst_rel", LAT, 3'b111, 3'b000, 3'b111);
        hold("rst_hold", 5, 3'b111);
        btn_raw = 3'b000;
        watch("rel_all", LAT, 3'b000, 3'b111, 3'b000);

        // 2: clean press on ch1, held 50 cycles, no auto-repeat.
        btn_raw = 3'b010;
        watch("clean", LAT, 3'b010, 3'b000, 3'b010);
        hold("clean_hold", 37, 3'b010);
        btn_raw = 3'b000;
        watch("clean_rel", LAT, 3'b000, 3'b010, 3'b000);

        // 3: bounce on ch0: 3-cycle toggles for 30 cycles, then stable high.
        for (int p = 0; p < 10; p++) begin
            btn_raw = (p % 2 == 0) ? 3'b001 : 3'b000;
            hold("bounce", 3, 3'b000);
        end
        btn_raw = 3'b001;
        watch("bounce_end", LAT, 3'b001, 3'b000, 3'b001);

        // 4: ch2 pressed, short dropout rejected, long dropout released.
        btn_raw = 3'b101;
        watch("ch2_press", LAT, 3'b100, 3'b000, 3'b101);
        btn_raw = 3'b001;
        hold("glitch5", 5, 3'b101);
        btn_raw = 3'b101;
        hold("glitch_rec", 15, 3'b101);
        btn_raw = 3'b001;
        watch("drop20", LAT, 3'b000, 3'b100, 3'b001);
        hold("drop20_tail", 7, 3'b001);
        btn_raw = 3'b101;
        watch("ch2_repress", LAT, 3'b100, 3'b000, 3'b101);

        // 5: simultaneous press on ch0 and ch2, ch1 silent.
        btn_raw = 3'b000;
        watch("sim_rel0", LAT, 3'b000, 3'b101, 3'b000);
        btn_raw = 3'b101;
        watch("sim_press", LAT, 3'b101, 3'b000, 3'b101);
        btn_raw = 3'b000;
        watch("sim_rel", LAT, 3'b000, 3'b101, 3'b000);

        // 6: async reset while ch1 is in ARM_P and ch0 is pressed.
        btn_raw = 3'b001;
        watch("pre6", LAT, 3'b001, 3'b000, 3'b001);
        btn_raw = 3'b011;
        hold("arm1", 5, 3'b001);
        rst_n = 1'b0;
        #1;
        check("async_rst", {29'd0, btn_level | btn_press | btn_release}, 32'd0);
        for (int i = 0; i < 15; i++) begin
            tick();
            check("rst6_out", {29'd0, btn_level | btn_press | btn_release}, 32'd0);
        end
        rst_n = 1'b1;
        watch("rst6_rel", LAT, 3'b011, 3'b000, 3'b011);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
